// File: rtl/time_keeper.sv
// time_keeper: registered BCD time of day driven by 1 Hz strobes,
// with debounced, auto-repeating hour/minute set buttons.
module time_keeper #(
  parameter int HOUR_24        = 1,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int REPEAT_DELAY   = 60,
  parameter int REPEAT_RATE    = 12
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick_1hz,
  input  logic       i_tick_120hz,
  input  logic       i_btn_hr,
  input  logic       i_btn_min,
  output logic [3:0] o_hr_t,
  output logic [3:0] o_hr_u,
  output logic [3:0] o_min_t,
  output logic [3:0] o_min_u,
  output logic [3:0] o_sec_t,
  output logic [3:0] o_sec_u,
  output logic       o_pm,
  output logic       o_colon,
  output logic       o_rollover
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [DW-1:0] AGREE_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_FIRST = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_NEXT  = HW'(REPEAT_DELAY + REPEAT_RATE);
  localparam logic [3:0] HR_T_RST = (HOUR_24 != 0) ? 4'd0 : 4'd1;
  localparam logic [3:0] HR_U_RST = (HOUR_24 != 0) ? 4'd0 : 4'd2;

  // Button index 0 is hour-set, 1 is minute-set.
  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] level_q, level_d;
  logic [1:0] prev_q, prev_d;
  logic [1:0] event_q, event_d;
  logic [1:0] fire;
  logic [1:0][DW-1:0] agree_q, agree_d;
  logic [1:0][HW-1:0] hold_q, hold_d, hold_inc;

  logic [3:0] hr_t_q, hr_t_d, hr_u_q, hr_u_d;
  logic [3:0] min_t_q, min_t_d, min_u_q, min_u_d;
  logic [3:0] sec_t_q, sec_t_d, sec_u_q, sec_u_d;
  logic       pm_q, pm_d;
  logic       colon_q, colon_d;
  logic       roll_q, roll_d;
  logic       pend_q, pend_d;

  logic ev_any, tick_req, apply;
  logic sec_wrap, min_wrap, hr_last;

  assign btn_raw = {i_btn_min, i_btn_hr};

  function automatic logic [7:0] bcd60_inc(
    input logic [3:0] t,
    input logic [3:0] u
  );
    logic [7:0] r;
    r = {t, u + 4'd1};
    if (u == 4'd9) begin
      r = (t == 4'd5) ? 8'd0 : {t + 4'd1, 4'd0};
    end
    return r;
  endfunction

  function automatic logic [8:0] hr_inc(
    input logic [3:0] t,
    input logic [3:0] u,
    input logic       pm
  );
    logic [8:0] r;
    r = {pm, t, u + 4'd1};
    if (u == 4'd9) r = {pm, t + 4'd1, 4'd0};
    if (HOUR_24 != 0) begin
      if (t == 4'd2 && u == 4'd3) r = 9'd0;
    end else begin
      // 11 -> 12 flips the meridiem; 12 -> 01 keeps it.
      if (t == 4'd1 && u == 4'd1) r = {~pm, 4'd1, 4'd2};
      if (t == 4'd1 && u == 4'd2) r = {pm, 4'd0, 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = level_q;
    level_d = level_q;
    agree_d = agree_q;
    hold_d  = hold_q;
    hold_inc = '0;
    fire    = '0;
    event_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (i_tick_120hz) begin
        if (sync2_q[b] != level_q[b]) begin
          if (agree_q[b] == AGREE_LAST) begin
            level_d[b] = ~level_q[b];
            agree_d[b] = '0;
          end else begin
            agree_d[b] = agree_q[b] + DW'(1);
          end
        end else begin
          agree_d[b] = '0;
        end
      end
      hold_inc[b] = hold_q[b] + HW'(1);
      // Hold time only counts while the press is stable high.
      if (!level_d[b]) begin
        hold_d[b] = '0;
      end else if (i_tick_120hz && level_q[b]) begin
        hold_d[b] = hold_inc[b];
        if (hold_inc[b] == HOLD_FIRST) begin
          fire[b] = 1'b1;
        end else if (hold_inc[b] == HOLD_NEXT) begin
          fire[b]   = 1'b1;
          hold_d[b] = HOLD_FIRST;
        end
      end
      event_d[b] = (level_q[b] & ~prev_q[b]) | fire[b];
    end
  end

  always_comb begin
    hr_t_d  = hr_t_q;
    hr_u_d  = hr_u_q;
    min_t_d = min_t_q;
    min_u_d = min_u_q;
    sec_t_d = sec_t_q;
    sec_u_d = sec_u_q;
    pm_d    = pm_q;
    sec_wrap = (sec_t_q == 4'd5) && (sec_u_q == 4'd9);
    min_wrap = (min_t_q == 4'd5) && (min_u_q == 4'd9);
    if (HOUR_24 != 0) begin
      hr_last = (hr_t_q == 4'd2) && (hr_u_q == 4'd3);
    end else begin
      hr_last = (hr_t_q == 4'd1) && (hr_u_q == 4'd1) && pm_q;
    end
    // A tick that meets a button event waits one slot in pend_q.
    ev_any   = |event_q;
    tick_req = i_tick_1hz | pend_q;
    apply    = tick_req & ~ev_any;
    pend_d   = ev_any & tick_req;
    colon_d  = colon_q ^ apply;
    roll_d   = apply & sec_wrap & min_wrap & hr_last;
    if (apply) begin
      {sec_t_d, sec_u_d} = bcd60_inc(sec_t_q, sec_u_q);
      if (sec_wrap) begin
        {min_t_d, min_u_d} = bcd60_inc(min_t_q, min_u_q);
        if (min_wrap) begin
          {pm_d, hr_t_d, hr_u_d} = hr_inc(hr_t_q, hr_u_q, pm_q);
        end
      end
    end
    if (event_q[1]) begin
      {min_t_d, min_u_d} = bcd60_inc(min_t_q, min_u_q);
      sec_t_d = 4'd0;
      sec_u_d = 4'd0;
    end
    if (event_q[0]) begin
      {pm_d, hr_t_d, hr_u_d} = hr_inc(hr_t_q, hr_u_q, pm_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      event_q <= '0;
      agree_q <= '0;
      hold_q  <= '0;
      hr_t_q  <= HR_T_RST;
      hr_u_q  <= HR_U_RST;
      min_t_q <= 4'd0;
      min_u_q <= 4'd0;
      sec_t_q <= 4'd0;
      sec_u_q <= 4'd0;
      pm_q    <= 1'b0;
      colon_q <= 1'b0;
      roll_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      event_q <= event_d;
      agree_q <= agree_d;
      hold_q  <= hold_d;
      hr_t_q  <= hr_t_d;
      hr_u_q  <= hr_u_d;
      min_t_q <= min_t_d;
      min_u_q <= min_u_d;
      sec_t_q <= sec_t_d;
      sec_u_q <= sec_u_d;
      pm_q    <= pm_d;
      colon_q <= colon_d;
      roll_q  <= roll_d;
      pend_q  <= pend_d;
    end
  end

  assign o_hr_t     = hr_t_q;
  assign o_hr_u     = hr_u_q;
  assign o_min_t    = min_t_q;
  assign o_min_u    = min_u_q;
  assign o_sec_t    = sec_t_q;
  assign o_sec_u    = sec_u_q;
  assign o_pm       = pm_q;
  assign o_colon    = colon_q;
  assign o_rollover = roll_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: 24 h and 12 h instances on shared stimulus,
// checked against a seconds-of-day reference model.
`timescale 1ns/1ps
module tb_time_keeper;
  localparam int DB = 3;
  localparam int RD = 60;
  localparam int RR = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic t1 = 1'b0;
  logic t120 = 1'b0;
  logic bh = 1'b0;
  logic bm = 1'b0;

  logic [3:0] a_ht, a_hu, a_mt, a_mu, a_st, a_su;
  logic [3:0] b_ht, b_hu, b_mt, b_mu, b_st, b_su;
  logic a_pm, a_col, a_ro, b_pm, b_col, b_ro;

  always #5 clk = ~clk;

  time_keeper #(
    .HOUR_24(1), .DEBOUNCE_TICKS(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) u24 (
    .i_clk(clk), .i_reset(rst),
    .i_tick_1hz(t1), .i_tick_120hz(t120),
    .i_btn_hr(bh), .i_btn_min(bm),
    .o_hr_t(a_ht), .o_hr_u(a_hu),
    .o_min_t(a_mt), .o_min_u(a_mu),
    .o_sec_t(a_st), .o_sec_u(a_su),
    .o_pm(a_pm), .o_colon(a_col), .o_rollover(a_ro)
  );

  time_keeper #(
    .HOUR_24(0), .DEBOUNCE_TICKS(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) u12 (
    .i_clk(clk), .i_reset(rst),
    .i_tick_1hz(t1), .i_tick_120hz(t120),
    .i_btn_hr(bh), .i_btn_min(bm),
    .o_hr_t(b_ht), .o_hr_u(b_hu),
    .o_min_t(b_mt), .o_min_u(b_mu),
    .o_sec_t(b_st), .o_sec_u(b_su),
    .o_pm(b_pm), .o_colon(b_col), .o_rollover(b_ro)
  );

  int checks = 0;
  int errors = 0;
  int tod = 0;
  logic mcol = 1'b0;

  typedef enum int {OP_TICK, OP_HR, OP_MIN, OP_BNC_H, OP_BNC_M} op_e;
  typedef struct {
    op_e op;
    int  eh;
    int  em;
    int  es;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] bcd(int h, int m, int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10),
            4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int h12(int h);
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  task automatic check_hms(input string nm, input int h,
                           input int m, input int s);
    chk({nm, ".t24"}, 32'({a_ht, a_hu, a_mt, a_mu, a_st, a_su}),
        32'(bcd(h, m, s)));
    chk({nm, ".t12"}, 32'({b_ht, b_hu, b_mt, b_mu, b_st, b_su}),
        32'(bcd(h12(h), m, s)));
    chk({nm, ".pm"}, 32'({a_pm, b_pm}), 32'({1'b0, h >= 12}));
    chk({nm, ".colon"}, 32'({a_col, b_col}), 32'({mcol, mcol}));
  endtask

  task automatic check_time(input string nm);
    check_hms(nm, tod / 3600, (tod / 60) % 60, tod % 60);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b == 0) bh = v;
    else bm = v;
  endtask

  task automatic tick120();
    t120 = 1'b1;
    cyc();
    t120 = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic hr_ev();
    tod = (((tod / 3600) + 1) % 24) * 3600 + tod % 3600;
  endtask

  task automatic min_ev();
    tod = (tod / 3600) * 3600 + ((((tod / 60) % 60) + 1) % 60) * 60;
  endtask

  task automatic do_tick();
    logic ro;
    t1 = 1'b1;
    cyc();
    t1 = 1'b0;
    ro = (tod == 86399);
    tod = (tod + 1) % 86400;
    mcol = ~mcol;
    chk("rollover", 32'({a_ro, b_ro}), 32'({ro, ro}));
    cyc();
    chk("ro_pulse", 32'({a_ro, b_ro}), 32'(0));
  endtask

  task automatic release_all();
    bh = 1'b0;
    bm = 1'b0;
    repeat (3) cyc();
    repeat (DB) tick120();
  endtask

  task automatic press(input int b, input int n);
    set_btn(b, 1'b1);
    repeat (3) cyc();
    repeat (n) tick120();
    release_all();
    if (b == 0) hr_ev();
    else min_ev();
  endtask

  task automatic bounce(input int b);
    set_btn(b, 1'b1);
    repeat (3) cyc();
    repeat (DB - 1) tick120();
    release_all();
  endtask

  task automatic press_both();
    bh = 1'b1;
    bm = 1'b1;
    repeat (3) cyc();
    repeat (DB) tick120();
    release_all();
    hr_ev();
    min_ev();
  endtask

  task automatic do_op(input op_e op);
    case (op)
      OP_TICK:  do_tick();
      OP_HR:    press(0, DB);
      OP_MIN:   press(1, DB);
      OP_BNC_H: bounce(0);
      default:  bounce(1);
    endcase
  endtask

  task automatic set_time(input int h, input int m, input int s);
    while (tod / 3600 != h) press(0, DB);
    press(1, DB);
    while ((tod / 60) % 60 != m) press(1, DB);
    repeat (s) do_tick();
  endtask

  initial begin
    tbl[0] = '{OP_MIN,   0, 1, 0};
    tbl[1] = '{OP_TICK,  0, 1, 1};
    tbl[2] = '{OP_HR,    1, 1, 1};
    tbl[3] = '{OP_BNC_M, 1, 1, 1};
    tbl[4] = '{OP_MIN,   1, 2, 0};
    tbl[5] = '{OP_TICK,  1, 2, 1};
    tbl[6] = '{OP_BNC_H, 1, 2, 1};
    tbl[7] = '{OP_HR,    2, 2, 1};

    cyc();
    cyc();
    check_hms("reset", 0, 0, 0);
    chk("reset.ro", 32'({a_ro, b_ro}), 32'(0));
    rst = 1'b0;
    cyc();
    check_hms("post_reset", 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].op);
      check_hms($sformatf("vec%0d", i), tbl[i].eh, tbl[i].em, tbl[i].es);
    end

    set_time(23, 59, 58);
    check_time("pre_midnight");
    do_tick();
    check_hms("t235959", 23, 59, 59);
    do_tick();
    check_hms("midnight", 0, 0, 0);

    set_time(11, 59, 59);
    do_tick();
    check_hms("noon", 12, 0, 0);

    set_time(12, 59, 59);
    do_tick();
    check_hms("one_pm", 13, 0, 0);

    set_time(10, 42, 37);
    bounce(1);
    check_hms("bounce", 10, 42, 37);
    press(1, 4);
    check_hms("clean4", 10, 43, 0);

    set_time(5, 0, 0);
    bh = 1'b1;
    repeat (3) cyc();
    for (int k = 1; k <= 100; k++) begin
      tick120();
      if (k == 62) check_hms("hold62", 6, 0, 0);
      if (k == 70) check_hms("hold70", 7, 0, 0);
    end
    release_all();
    repeat (5) hr_ev();
    check_hms("hold", 10, 0, 0);

    set_time(10, 59, 30);
    bm = 1'b1;
    repeat (3) cyc();
    repeat (DB - 1) tick120();
    t120 = 1'b1;
    cyc();
    t120 = 1'b0;
    cyc();
    t1 = 1'b1;
    cyc();
    t1 = 1'b0;
    min_ev();
    check_hms("coin1", 10, 0, 0);
    chk("coin1.ro", 32'({a_ro, b_ro}), 32'(0));
    cyc();
    tod = tod + 1;
    mcol = ~mcol;
    check_hms("coin2", 10, 0, 1);
    chk("coin2.ro", 32'({a_ro, b_ro}), 32'(0));
    release_all();
    check_time("coin3");

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        5: press(0, $urandom_range(DB, DB + 3));
        6: press(1, $urandom_range(DB, DB + 3));
        7: bounce($urandom_range(0, 1));
        8: press_both();
        default: do_tick();
      endcase
      check_time("rnd");
    end

    bm = 1'b1;
    repeat (3) cyc();
    repeat (DB - 1) tick120();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    tod = 0;
    mcol = 1'b0;
    check_hms("rst_mid", 0, 0, 0);
    repeat (3) cyc();
    repeat (DB - 1) tick120();
    check_hms("rst_redb", 0, 0, 0);
    tick120();
    min_ev();
    check_hms("rst_event", 0, 1, 0);
    tick120();
    check_hms("rst_once", 0, 1, 0);
    release_all();
    check_time("rst_rel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day core for the board clock. Consumes the one-cycle 1 Hz and 120 Hz strobes produced by the pulse generator and keeps hours/minutes/seconds as registered BCD digits for the display stage. Also debounces two raw set buttons, sampled on the 120 Hz strobe, with press-and-hold auto-repeat.

## Interface
- HOUR_24, default 1: 1 = 00–23 hours; 0 = 12-hour display 12,01..11 with AM/PM flag.
- DEBOUNCE_TICKS, default 3: consecutive agreeing 120 Hz samples needed to change a debounced level.
- REPEAT_DELAY, default 60: 120 Hz ticks held before the first auto-repeat (0.5 s).
- REPEAT_RATE, default 12: 120 Hz ticks between auto-repeats (10/s).
- i_clk  in  1  12 MHz system clock.
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clk.
- i_tick_1hz  in  1  one-cycle strobe, once per second.
- i_tick_120hz  in  1  one-cycle strobe, 120 per second.
- i_btn_hr  in  1  raw, asynchronous, active-high hour-set button.
- i_btn_min  in  1  raw, asynchronous, active-high minute-set button.
- o_hr_t, o_hr_u  out  4 each  hour tens/units, BCD.
- o_min_t, o_min_u  out  4 each  minute tens/units, BCD.
- o_sec_t, o_sec_u  out  4 each  second tens/units, BCD.
- o_pm  out  1  PM flag; always 0 when HOUR_24=1.
- o_colon  out  1  toggles on every applied 1 Hz advance.
- o_rollover  out  1  one-cycle pulse on natural midnight rollover.

## Operation
- Reset values:
  - Time: HOUR_24=1 gives 00:00:00; HOUR_24=0 gives 12:00:00.
  - Flags: o_pm=0, o_colon=0, o_rollover=0.
  - Internal state: debounced levels 0, all counters 0, pending tick 0.
- Button path, per button:
  - Two-flop synchroniser on i_clk.
  - On each i_tick_120hz: if the synced sample differs from the debounced level, increment an agree counter; otherwise clear it. When the counter reaches DEBOUNCE_TICKS, flip the debounced level and clear the counter.
  - Debounced 0→1 generates one increment event, a registered one-cycle pulse.
  - While the level stays 1, a hold counter runs on 120 Hz ticks. Further events occur at REPEAT_DELAY ticks, then every REPEAT_RATE ticks. The hold counter clears on release.
- Seconds advance, on an applied tick:
  - sec_u+1; 9→0 carries to sec_t.
  - sec_t 5→0 carries to minutes. Minutes follow the same rule and carry to hours.
- Hours:
  - 24 h: 23→00.
  - 12 h: 11→12 toggles o_pm; 12→01 does not toggle.
- Natural rollover:
  - 24 h: 23:59:59→00:00:00.
  - 12 h: 11:59:59 PM→12:00:00 AM.
  - Asserts o_rollover for exactly the cycle the new value first appears.
- Minute event: minutes+1 with 59→00 wrap and no hour carry; seconds←00.
- Hour event: hours+1 with the same wrap/o_pm rules; no other effect. Button wraps never assert o_rollover.
- Both events in the same cycle are both applied.
- Tick coinciding with any button event: the tick is not lost.
  - Set a one-bit pending flag; apply the tick on the next cycle that has no button event.
  - A second tick arriving while pending is set is dropped (cannot occur at real rates).
- o_colon toggles only when a tick is actually applied.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- 1 Hz: the digits update on the edge sampling i_tick_1hz=1 and are visible the following cycle (latency 1).
- Deferred tick: latency 2 or more, applied on the first event-free cycle.
- Button: the debounced level flips on the edge of the confirming 120 Hz tick. The event pulse is high the next cycle. Digits change on the edge ending the event cycle (2 edges after the confirming tick).
- Minimum press-to-event: DEBOUNCE_TICKS 120 Hz ticks (about 25 ms at default) plus 2 sync cycles.
- Reset mid-press: all state returns to reset values. A button still held after reset must be re-debounced, and then produces one fresh event.

## Test plan
- Reset then release, HOUR_24=1: digits 0,0,0,0,0,0, o_pm=0, o_colon=0. With HOUR_24=0: hours read 1,2.
- Preload 23:59:58, send two 1 Hz ticks: reads 23:59:59, then 00:00:00 with o_rollover high exactly one cycle; o_colon toggled twice.
- HOUR_24=0 at 11:59:59 AM, one tick: 12:00:00 with o_pm=1 and o_rollover=0. At 12:59:59 PM, one tick: 01:00:00, o_pm stays 1.
- Bounce i_btn_min high for 2 consecutive 120 Hz samples then low: no change. A clean press of 4 samples at 10:42:37: 10:43:00, one event only.
- Hold i_btn_hr for 100 ticks from 05:00:00: the first event at debounce, then at REPEAT_DELAY and at +REPEAT_RATE, +2×REPEAT_RATE, +3×REPEAT_RATE (ticks 72, 84, 96). Final 10:00:00, minutes untouched.
- Force the minute event and i_tick_1hz in the same cycle at 10:59:30: 10:00:00 on cycle+1, then 10:00:01 on cycle+2; no hour carry, o_rollover=0.
